alu_ctrl_seq: RTL and testbench

Parametrised, registered successor to the combinational ALU controller. It decodes {ALUOp, funct} into an ALU control code and registers it into the ID/EX boundary. It adds stall/flush, an illegal-op flag and a defined default code. Multi-cycle MULT/DIV ops are sequenced by a busy countdown that back-pressures the decode stage.

---
 rtl/alu_ctrl_pkg.sv | 42 ++++
 rtl/alu_ctrl_dec.sv | 63 ++++++
 rtl/alu_ctrl_seq.sv | 109 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU controller: ALUOp classes, R-type funct
// codes and ALU control codes.
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_W    = 3;
  localparam int unsigned ALU_FUNCT_W = 6;
  localparam int unsigned ALU_CTRL_W  = 4;

  // ALUOp classes from the main decoder
  localparam logic [ALU_OP_W-1:0] OP_ADD   = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_SUB   = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_RTYPE = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_SLT   = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_OR    = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_AND   = 3'b101;

  // R-type funct field values
  localparam logic [ALU_FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [ALU_FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [ALU_FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [ALU_FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [ALU_FUNCT_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [ALU_FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [ALU_FUNCT_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [ALU_FUNCT_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [ALU_FUNCT_W-1:0] FN_MULT = 6'b011000;
  localparam logic [ALU_FUNCT_W-1:0] FN_DIV  = 6'b011010;

  // ALU control codes
  localparam logic [ALU_CTRL_W-1:0] CTRL_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] CTRL_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] CTRL_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] CTRL_NOR  = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SLL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SRL  = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] CTRL_MULT = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] CTRL_DIV  = 4'b1011;
  localparam logic [ALU_CTRL_W-1:0] CTRL_NOP  = 4'b1111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode.
// Ports: alu_op, funct in; ctrl, shamt_sel, is_mul, is_div, illegal out (all _c style, unregistered).
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               shamt_sel,
  output logic               is_mul,
  output logic               is_div,
  output logic               illegal
);

  // Every path falls back to NOP so the code is never undefined.
  always_comb begin
    ctrl      = CTRL_W'(CTRL_NOP);
    shamt_sel = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      OP_W'(OP_ADD): ctrl = CTRL_W'(CTRL_ADD);
      OP_W'(OP_SUB): ctrl = CTRL_W'(CTRL_SUB);
      OP_W'(OP_SLT): ctrl = CTRL_W'(CTRL_SLT);
      OP_W'(OP_OR):  ctrl = CTRL_W'(CTRL_OR);
      OP_W'(OP_AND): ctrl = CTRL_W'(CTRL_AND);
      OP_W'(OP_RTYPE): begin
        case (funct)
          FUNCT_W'(FN_AND):  ctrl = CTRL_W'(CTRL_AND);
          FUNCT_W'(FN_OR):   ctrl = CTRL_W'(CTRL_OR);
          FUNCT_W'(FN_ADD):  ctrl = CTRL_W'(CTRL_ADD);
          FUNCT_W'(FN_SUB):  ctrl = CTRL_W'(CTRL_SUB);
          FUNCT_W'(FN_SLT):  ctrl = CTRL_W'(CTRL_SLT);
          FUNCT_W'(FN_NOR):  ctrl = CTRL_W'(CTRL_NOR);
          FUNCT_W'(FN_SLL): begin
            ctrl      = CTRL_W'(CTRL_SLL);
            shamt_sel = 1'b1;
          end
          FUNCT_W'(FN_SRL): begin
            ctrl      = CTRL_W'(CTRL_SRL);
            shamt_sel = 1'b1;
          end
          FUNCT_W'(FN_MULT): begin
            ctrl   = CTRL_W'(CTRL_MULT);
            is_mul = 1'b1;
          end
          FUNCT_W'(FN_DIV): begin
            ctrl   = CTRL_W'(CTRL_DIV);
            is_div = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller at the ID/EX boundary with stall/flush and a
// busy countdown that holds EX for multi-cycle MULT/DIV.
// Ports: clk_i, rst_i (sync, active-high), valid_i, ALUOp_i, funct_i,
//   stall_i, flush_i in; ready_o (combinational), ALUCtrl_o, valid_o,
//   shamt_sel_o, illegal_o, busy_o (registered) out.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               valid_o,
  output logic               shamt_sel_o,
  output logic               illegal_o,
  output logic               busy_o
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_shamt, dec_mul, dec_div, dec_illegal;

  logic [CTRL_W-1:0] ctrl_n;
  logic              valid_n, shamt_n, illegal_n, busy_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  alu_ctrl_dec #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_dec (
    .alu_op    (ALUOp_i),
    .funct     (funct_i),
    .ctrl      (dec_ctrl),
    .shamt_sel (dec_shamt),
    .is_mul    (dec_mul),
    .is_div    (dec_div),
    .illegal   (dec_illegal)
  );

  assign ready_o = ~busy_o & ~stall_i;

  // Next-state: flush > stall > busy countdown > load.
  always_comb begin
    ctrl_n    = ALUCtrl_o;
    valid_n   = valid_o;
    shamt_n   = shamt_sel_o;
    illegal_n = illegal_o;
    busy_n    = busy_o;
    cnt_n     = cnt_q;
    if (flush_i) begin
      ctrl_n    = CTRL_W'(CTRL_NOP);
      valid_n   = 1'b0;
      shamt_n   = 1'b0;
      illegal_n = 1'b0;
      busy_n    = 1'b0;
      cnt_n     = CNT_W'(0);
    end else if (stall_i) begin
      // hold everything
    end else if (cnt_q != CNT_W'(0)) begin
      cnt_n  = cnt_q - CNT_W'(1);
      busy_n = (cnt_q != CNT_W'(1));
    end else begin
      valid_n   = valid_i;
      ctrl_n    = valid_i ? dec_ctrl : CTRL_W'(CTRL_NOP);
      shamt_n   = valid_i & dec_shamt;
      illegal_n = valid_i & dec_illegal;
      busy_n    = 1'b0;
      if (valid_i && dec_mul) begin
        cnt_n  = CNT_W'(MUL_LAT - 1);
        busy_n = (MUL_LAT > 1);
      end else if (valid_i && dec_div) begin
        cnt_n  = CNT_W'(DIV_LAT - 1);
        busy_n = (DIV_LAT > 1);
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ALUCtrl_o   <= CTRL_W'(CTRL_NOP);
      valid_o     <= 1'b0;
      shamt_sel_o <= 1'b0;
      illegal_o   <= 1'b0;
      busy_o      <= 1'b0;
      cnt_q       <= CNT_W'(0);
    end else begin
      ALUCtrl_o   <= ctrl_n;
      valid_o     <= valid_n;
      shamt_sel_o <= shamt_n;
      illegal_o   <= illegal_n;
      busy_o      <= busy_n;
      cnt_q       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq: expected register contents
// are queued as each step is driven and compared after the clock edge.
module tb_alu_ctrl_seq;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  localparam logic [2:0] RT  = 3'b010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       v;
    logic       sh;
    logic       il;
    logic       bz;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i, valid_i, stall_i, flush_i;
  logic [2:0] ALUOp_i;
  logic [5:0] funct_i;
  logic       ready_o, valid_o, shamt_sel_o, illegal_o, busy_o;
  logic [3:0] ALUCtrl_o;

  int checks = 0;
  int passed = 0;
  exp_t sb[$];

  alu_ctrl_seq #(
    .OP_W(3), .FUNCT_W(6), .CTRL_W(4),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ALUOp_i     (ALUOp_i),
    .funct_i     (funct_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .ALUCtrl_o   (ALUCtrl_o),
    .valid_o     (valid_o),
    .shamt_sel_o (shamt_sel_o),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(input logic [3:0] c, input logic v, input logic sh,
                              input logic il, input logic bz);
    exp_t e;
    e.ctrl = c; e.v = v; e.sh = sh; e.il = il; e.bz = bz;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  // Drive one cycle of inputs, optionally check ready_o, queue the expected
  // register state, then compare it after the edge.
  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [2:0] op, input logic [5:0] fn,
                      input logic st, input logic fl,
                      input logic chk_rdy, input logic rdy_exp, input exp_t e);
    exp_t got;
    rst_i = rst; valid_i = v; ALUOp_i = op; funct_i = fn;
    stall_i = st; flush_i = fl;
    #1;
    if (chk_rdy) chk({tag, ".ready"}, {3'b0, ready_o}, {3'b0, rdy_exp});
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    chk({tag, ".ctrl"},    ALUCtrl_o,            got.ctrl);
    chk({tag, ".valid"},   {3'b0, valid_o},      {3'b0, got.v});
    chk({tag, ".shamt"},   {3'b0, shamt_sel_o},  {3'b0, got.sh});
    chk({tag, ".illegal"}, {3'b0, illegal_o},    {3'b0, got.il});
    chk({tag, ".busy"},    {3'b0, busy_o},       {3'b0, got.bz});
  endtask

  localparam exp_t RST = '{ctrl: 4'hF, v: 1'b0, sh: 1'b0, il: 1'b0, bz: 1'b0};

  initial begin
    // reset, then two idle cycles
    step("reset", 1, 0, 3'b000, 6'h00, 0, 0, 0, 1'b0, RST);
    step("idle0", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b1, RST);
    step("idle1", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b1, RST);

    // back-to-back R-type ops
    step("r_and", 0, 1, RT, 6'b100100, 0, 0, 1, 1'b1, mk(4'b0000, 1, 0, 0, 0));
    step("r_or",  0, 1, RT, 6'b100101, 0, 0, 1, 1'b1, mk(4'b0001, 1, 0, 0, 0));
    step("r_add", 0, 1, RT, 6'b100000, 0, 0, 1, 1'b1, mk(4'b0010, 1, 0, 0, 0));
    step("r_sub", 0, 1, RT, 6'b100010, 0, 0, 1, 1'b1, mk(4'b0110, 1, 0, 0, 0));
    step("r_slt", 0, 1, RT, 6'b101010, 0, 0, 1, 1'b1, mk(4'b0111, 1, 0, 0, 0));
    step("r_nor", 0, 1, RT, 6'b100111, 0, 0, 1, 1'b1, mk(4'b1100, 1, 0, 0, 0));
    step("r_sll", 0, 1, RT, 6'b000000, 0, 0, 1, 1'b1, mk(4'b1000, 1, 1, 0, 0));
    step("r_srl", 0, 1, RT, 6'b000010, 0, 0, 1, 1'b1, mk(4'b1001, 1, 1, 0, 0));
    step("r_ill", 0, 1, RT, 6'b111111, 0, 0, 1, 1'b1, mk(4'b1111, 1, 0, 1, 0));
    step("bubble", 0, 0, RT, 6'b111111, 0, 0, 1, 1'b1, RST);

    // direct ALUOp classes and an unused code
    step("op_add", 0, 1, 3'b000, 6'h3F, 0, 0, 1, 1'b1, mk(4'b0010, 1, 0, 0, 0));
    step("op_sub", 0, 1, 3'b001, 6'h3F, 0, 0, 1, 1'b1, mk(4'b0110, 1, 0, 0, 0));
    step("op_slt", 0, 1, 3'b011, 6'h3F, 0, 0, 1, 1'b1, mk(4'b0111, 1, 0, 0, 0));
    step("op_or",  0, 1, 3'b100, 6'h3F, 0, 0, 1, 1'b1, mk(4'b0001, 1, 0, 0, 0));
    step("op_and", 0, 1, 3'b101, 6'h3F, 0, 0, 1, 1'b1, mk(4'b0000, 1, 0, 0, 0));
    step("op_110", 0, 1, 3'b110, 6'h3F, 0, 0, 1, 1'b1, mk(4'b1111, 1, 0, 0, 0));
    step("op_111", 0, 1, 3'b111, 6'h00, 0, 0, 1, 1'b1, mk(4'b1111, 1, 0, 0, 0));

    // stall holds a single-cycle op and drops the presented input
    step("st_ld",  0, 1, 3'b000, 6'h00, 0, 0, 1, 1'b1, mk(4'b0010, 1, 0, 0, 0));
    step("st_hd",  0, 1, 3'b100, 6'h00, 1, 0, 1, 1'b0, mk(4'b0010, 1, 0, 0, 0));

    // MULT: busy 3 cycles, code held 4 cycles, next op (ADD) on cycle 5
    step("mul_ld", 0, 1, RT, F_MULT, 0, 0, 1, 1'b1, mk(4'b1010, 1, 0, 0, 1));
    for (int i = 1; i < int'(MUL_LAT); i++)
      step("mul_bz", 0, 1, 3'b000, 6'h00, 0, 0, 1, 1'b0,
           mk(4'b1010, 1, 0, 0, (i < int'(MUL_LAT) - 1)));
    step("mul_nx", 0, 1, 3'b000, 6'h00, 0, 0, 1, 1'b1, mk(4'b0010, 1, 0, 0, 0));

    // DIV with a 5-cycle stall mid-op: busy for DIV_LAT-1+5 cycles
    step("div_ld", 0, 1, RT, F_DIV, 0, 0, 1, 1'b1, mk(4'b1011, 1, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      step("div_pre", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b0, mk(4'b1011, 1, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      step("div_stl", 0, 1, 3'b000, 6'h00, 1, 0, 1, 1'b0, mk(4'b1011, 1, 0, 0, 1));
    for (int i = 0; i < int'(DIV_LAT) - 11; i++)
      step("div_post", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b0,
           mk(4'b1011, 1, 0, 0, (i < int'(DIV_LAT) - 12)));
    step("div_nx", 0, 1, RT, 6'b100101, 0, 0, 1, 1'b1, mk(4'b0001, 1, 0, 0, 0));

    // DIV flushed at counter=10, with a valid op presented in the same cycle
    step("dfl_ld", 0, 1, RT, F_DIV, 0, 0, 1, 1'b1, mk(4'b1011, 1, 0, 0, 1));
    for (int i = 0; i < int'(DIV_LAT) - 11; i++)
      step("dfl_bz", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b0, mk(4'b1011, 1, 0, 0, 1));
    step("dfl_fl", 0, 1, 3'b000, 6'h00, 0, 1, 1, 1'b0, RST);
    step("dfl_nx", 0, 1, RT, 6'b100010, 0, 0, 1, 1'b1, mk(4'b0110, 1, 0, 0, 0));

    // synchronous reset mid-MULT
    step("mrs_ld", 0, 1, RT, F_MULT, 0, 0, 1, 1'b1, mk(4'b1010, 1, 0, 0, 1));
    step("mrs_bz", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b0, mk(4'b1010, 1, 0, 0, 1));
    step("mrs_rs", 1, 1, 3'b000, 6'h00, 0, 0, 1, 1'b0, RST);
    step("mrs_nx", 0, 1, RT, 6'b000000, 0, 0, 1, 1'b1, mk(4'b1000, 1, 1, 0, 0));
    step("mrs_id", 0, 0, 3'b000, 6'h00, 0, 0, 1, 1'b1, RST);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
